// File: rtl/cmd_bus_encoder.sv
// ---------------------------------------------------------------------------
// cmd_bus_encoder
//   Serialises one high-level command per valid/ready handshake onto the
//   3-bit command bus (c_bus -> C2..C0) with strobe c_clk. The receiver
//   samples c_bus on the falling c_clk edge through long input filters, so
//   every symbol is framed as SETUP (bus stable, strobe low), HIGH (strobe
//   high) and HOLD (strobe low, bus still stable). A GAP follows the last
//   symbol of each command.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   cmd_valid  command request (held by upstream until cmd_ready)
//   cmd_ready  encoder idle; accept on cmd_valid & cmd_ready
//   cmd_op     0 PAUSE,1 PLUS,2 MINUS,3 BALLAST_P,4 BALLAST_N,5 START,
//              6 SHUTDOWN,7 DISCHARGE
//   cmd_arg    DISCHARGE final symbol: 0 -> 1, 1 -> 3
//   c_bus      symbol bus
//   c_clk      strobe, receiver samples on its falling edge
//   busy       ~cmd_ready
//   done       one-cycle pulse when a command (including its gap) completes
// ---------------------------------------------------------------------------
module cmd_bus_encoder #(
   parameter int T_SETUP = 64,
   parameter int T_HIGH  = 128,
   parameter int T_HOLD  = 64,
   parameter int T_GAP   = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic       cmd_arg,
   output logic [2:0] c_bus,
   output logic       c_clk,
   output logic       busy,
   output logic       done
);

   if (T_SETUP < 32 || T_HIGH < 32 || T_HOLD < 32 || T_GAP < 1) begin : g_param_err
      $error("cmd_bus_encoder: timing parameter below its minimum");
   end

   localparam int TMAX_A = (T_SETUP > T_HIGH) ? T_SETUP : T_HIGH;
   localparam int TMAX_B = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
   localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int TW     = $clog2(TMAX) + 1;

   localparam logic [2:0] OP_PAUSE     = 3'd0;
   localparam logic [2:0] OP_START     = 3'd5;
   localparam logic [2:0] OP_DISCHARGE = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_HOLD,
      S_GAP
   } state_t;

   // Symbol idx of a command. The single-symbol ops transmit their own code.
   function automatic logic [2:0] sym_of(input logic [2:0] op, input logic arg,
                                         input logic [2:0] idx);
      logic [2:0] s;
      s = op;
      case (op)
         OP_PAUSE: s = 3'd0;
         OP_START: s = (idx == 3'd0) ? 3'd5 : 3'd0;
         OP_DISCHARGE: begin
            case (idx)
               3'd0, 3'd2: s = 3'd7;
               3'd1, 3'd3: s = 3'd0;
               default:    s = arg ? 3'd3 : 3'd1;
            endcase
         end
         default: s = op;
      endcase
      return s;
   endfunction

   function automatic logic [2:0] len_of(input logic [2:0] op);
      logic [2:0] n;
      case (op)
         OP_PAUSE, OP_START: n = 3'd2;
         OP_DISCHARGE:       n = 3'd5;
         default:            n = 3'd1;
      endcase
      return n;
   endfunction

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [2:0]      idx_q, idx_d;
   logic [2:0]      len_q, len_d;
   logic [2:0]      op_q, op_d;
   logic            arg_q, arg_d;
   logic [2:0]      c_bus_q, c_bus_d;
   logic            c_clk_q, c_clk_d;
   logic            rdy_q, rdy_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            tick;

   // Down-counter expires when it is decremented from 1.
   assign tick = (timer_q == TW'(1));

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      len_d   = len_q;
      op_d    = op_q;
      arg_d   = arg_q;
      c_bus_d = c_bus_q;
      c_clk_d = c_clk_q;
      rdy_d   = rdy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && rdy_q) begin
               op_d    = cmd_op;
               arg_d   = cmd_arg;
               len_d   = len_of(cmd_op);
               idx_d   = 3'd0;
               c_bus_d = sym_of(cmd_op, cmd_arg, 3'd0);
               timer_d = TW'(T_SETUP);
               rdy_d   = 1'b0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            timer_d = timer_q - TW'(1);
            if (tick) begin
               c_clk_d = 1'b1;
               timer_d = TW'(T_HIGH);
               state_d = S_HIGH;
            end
         end
         S_HIGH: begin
            timer_d = timer_q - TW'(1);
            if (tick) begin
               c_clk_d = 1'b0;
               timer_d = TW'(T_HOLD);
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            timer_d = timer_q - TW'(1);
            if (tick) begin
               if (idx_q == len_q - 3'd1) begin
                  timer_d = TW'(T_GAP);
                  state_d = S_GAP;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  c_bus_d = sym_of(op_q, arg_q, idx_q + 3'd1);
                  timer_d = TW'(T_SETUP);
                  state_d = S_SETUP;
               end
            end
         end
         S_GAP: begin
            timer_d = timer_q - TW'(1);
            if (tick) begin
               done_d  = 1'b1;
               rdy_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            rdy_d   = 1'b1;
            c_clk_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      busy_d = ~rdy_d;
   end

   // Reset drops the strobe immediately; the receiver never sees the final
   // falling edge of an interrupted command and discards it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         op_q    <= '0;
         arg_q   <= 1'b0;
         c_bus_q <= '0;
         c_clk_q <= 1'b0;
         rdy_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         op_q    <= op_d;
         arg_q   <= arg_d;
         c_bus_q <= c_bus_d;
         c_clk_q <= c_clk_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign cmd_ready = rdy_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign c_bus     = c_bus_q;
   assign c_clk     = c_clk_q;

endmodule

// File: tb/tb_cmd_bus_encoder.sv
// ---------------------------------------------------------------------------
// tb_cmd_bus_encoder
//   Scoreboard bench for cmd_bus_encoder at default timing. Each accepted
//   command pushes its expected symbols, rise/fall times and done time; a
//   negedge monitor pops and compares as the DUT produces them, and also
//   checks bus stability around every strobe.
// ---------------------------------------------------------------------------
module tb_cmd_bus_encoder;
   localparam int TS  = 64;
   localparam int TH  = 128;
   localparam int THD = 64;
   localparam int TG  = 256;
   localparam int P   = TS + TH + THD;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic       cmd_arg;
   logic [2:0] c_bus;
   logic       c_clk;
   logic       busy;
   logic       done;

   cmd_bus_encoder #(.T_SETUP(TS), .T_HIGH(TH), .T_HOLD(THD), .T_GAP(TG)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .c_bus(c_bus), .c_clk(c_clk),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_tests = 0;
   int n_fail  = 0;

   logic [2:0] sym_q[$];
   int         rise_q[$];
   int         fall_q[$];
   int         done_q[$];
   logic [2:0] last_sym = 3'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Independent reference of the transmitted symbol sequences.
   task automatic push_exp(input logic [2:0] op, input logic arg, input int a,
                           output logic [2:0] first);
      logic [2:0] s[5];
      int n;
      case (op)
         3'd0: begin s[0] = 3'd0; s[1] = 3'd0; n = 2; end
         3'd5: begin s[0] = 3'd5; s[1] = 3'd0; n = 2; end
         3'd7: begin
            s[0] = 3'd7; s[1] = 3'd0; s[2] = 3'd7; s[3] = 3'd0;
            s[4] = arg ? 3'd3 : 3'd1; n = 5;
         end
         default: begin s[0] = op; n = 1; end
      endcase
      for (int i = 0; i < n; i++) begin
         sym_q.push_back(s[i]);
         rise_q.push_back(a + TS + i * P);
         fall_q.push_back(a + TS + TH + i * P);
      end
      done_q.push_back(a + n * P + TG);
      last_sym = s[n-1];
      first    = s[0];
   endtask

   // Monitor: sampled on negedge, away from the active edge.
   logic       prev_clk = 1'b0;
   logic [2:0] prev_bus = 3'd0;
   int         last_fall = -1000;
   int         last_chg  = -1000;

   always @(negedge clk) begin
      if (rst) begin
         prev_clk = c_clk;
         prev_bus = c_bus;
      end else begin
         if (c_bus !== prev_bus) begin
            chk("bus_chg_clk_low", 32'(c_clk), 32'd0);
            chk("bus_chg_after_hold", 32'((cyc - last_fall) >= THD), 32'd1);
            last_chg = cyc;
         end
         if (!prev_clk && c_clk) begin
            chk("rise_after_setup", 32'((cyc - last_chg) >= TS), 32'd1);
            chk("rise_expected", 32'(rise_q.size() > 0), 32'd1);
            if (rise_q.size() > 0) chk("rise_time", 32'(cyc), 32'(rise_q.pop_front()));
         end
         if (prev_clk && !c_clk) begin
            last_fall = cyc;
            chk("fall_expected", 32'(sym_q.size() > 0), 32'd1);
            if (sym_q.size() > 0) begin
               chk("fall_sym", 32'(c_bus), 32'(sym_q.pop_front()));
               chk("fall_time", 32'(cyc), 32'(fall_q.pop_front()));
            end
         end
         if (done) begin
            chk("done_expected", 32'(done_q.size() > 0), 32'd1);
            if (done_q.size() > 0) chk("done_time", 32'(cyc), 32'(done_q.pop_front()));
            chk("ready_at_done", 32'(cmd_ready), 32'd1);
            chk("bus_held", 32'(c_bus), 32'(last_sym));
         end
         prev_clk = c_clk;
         prev_bus = c_bus;
      end
   end

   // Issue one command. hold keeps cmd_valid high afterwards with a scrambled
   // op; b2b expects acceptance in the cycle of the previous done.
   task automatic send(input logic [2:0] op, input logic arg, input bit hold, input bit b2b);
      int w;
      int a;
      logic [2:0] first;
      @(negedge clk);
      cmd_op    = op;
      cmd_arg   = arg;
      cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 5000) begin
         @(negedge clk);
         w++;
      end
      chk("accept_wait", 32'(cmd_ready), 32'd1);
      if (!cmd_ready) begin
         cmd_valid = 1'b0;
         return;
      end
      if (b2b) chk("b2b_with_done", 32'(done), 32'd1);
      a = cyc + 1;
      @(posedge clk);
      #1;
      push_exp(op, arg, a, first);
      chk("ready_low", 32'(cmd_ready), 32'd0);
      chk("busy_high", 32'(busy), 32'd1);
      chk("sym0", 32'(c_bus), 32'(first));
      if (hold) begin
         cmd_op  = 3'($urandom);
         cmd_arg = ~arg;
      end else begin
         cmd_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((done_q.size() + sym_q.size()) > 0 && w < 10000) begin
         @(negedge clk);
         w++;
      end
      chk("drain", 32'(done_q.size() + sym_q.size()), 32'd0);
   endtask

   initial begin
      int w;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_arg   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_c_bus", 32'(c_bus), 32'd0);
      chk("rst_c_clk", 32'(c_clk), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst = 1'b0;

      send(3'd1, 1'b0, 1'b0, 1'b0);  drain();   // PLUS
      send(3'd5, 1'b0, 1'b0, 1'b0);  drain();   // START
      send(3'd7, 1'b1, 1'b0, 1'b0);  drain();   // DISCHARGE, last symbol 3
      send(3'd7, 1'b0, 1'b0, 1'b0);  drain();   // DISCHARGE, last symbol 1

      // PAUSE then SHUTDOWN back to back, op scrambled while busy.
      send(3'd0, 1'b0, 1'b1, 1'b0);
      repeat (300) begin
         @(negedge clk);
         cmd_op = 3'($urandom);
      end
      send(3'd6, 1'b0, 1'b0, 1'b1);
      drain();

      // Every op back to back.
      for (int i = 0; i < 8; i++)
         send(3'(i), 1'(i), (i != 7), (i != 0));
      drain();

      // Reset during HIGH of DISCHARGE symbol 2.
      send(3'd7, 1'b1, 1'b0, 1'b0);
      w = 0;
      while (rise_q.size() > 2 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      chk("rst_test_reach_high", 32'(rise_q.size()), 32'd2);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_c_clk", 32'(c_clk), 32'd0);
      chk("midrst_c_bus", 32'(c_bus), 32'd0);
      sym_q.delete();
      rise_q.delete();
      fall_q.delete();
      done_q.delete();
      last_sym = 3'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_after_rst", 32'(cmd_ready), 32'd1);
      chk("busy_after_rst", 32'(busy), 32'd0);
      repeat (600) @(negedge clk);
      chk("idle_after_rst_clk", 32'(c_clk), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
